ram_arbiter: RTL and testbench

- Shares the single-port data RAM between the instruction-fetch port (read-only) and the load/store port (read/write).
- Each requester uses a req/gnt handshake and a registered response with rvalid/rready backpressure.
- Sits between the core's fetch/memory stages and the RAM.
- Drives the RAM's enable, byte-write-enable, address and write-data inputs, and consumes its combinational read data.

---
 rtl/ram_arbiter_pkg.sv | 13 +
 rtl/ram_arbiter_if.sv | 50 +++++
 rtl/ram_arbiter_rsp_slot.sv | 35 +++
 rtl/ram_arbiter.sv | 126 ++++++++++++
 tb/tb_ram_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared bus widths and port identifiers for the fetch/load-store RAM arbiter.
package ram_arbiter_pkg;

  localparam int ADDR_BUS    = 32;
  localparam int DATA_BUS    = 32;
  localparam int MEM_SEL_BUS = DATA_BUS / 8;

  typedef enum logic {
    PORT_INST = 1'b0,
    PORT_DATA = 1'b1
  } port_id_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester handshakes plus RAM-side signals of the arbiter, grouped as one bus.
interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_BUS,
  parameter int DATA_WIDTH = DATA_BUS,
  parameter int BE_WIDTH   = MEM_SEL_BUS
);

  logic                  inst_req;
  logic [ADDR_WIDTH-1:0] inst_addr;
  logic                  inst_gnt;
  logic                  inst_rvalid;
  logic [DATA_WIDTH-1:0] inst_rdata;
  logic                  inst_rready;

  logic                  data_req;
  logic [BE_WIDTH-1:0]   data_we;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic [DATA_WIDTH-1:0] data_wdata;
  logic                  data_gnt;
  logic                  data_rvalid;
  logic [DATA_WIDTH-1:0] data_rdata;
  logic                  data_rready;

  logic                  ram_en;
  logic [BE_WIDTH-1:0]   ram_write_en;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_write_data;
  logic [DATA_WIDTH-1:0] ram_read_data;

  modport slave (
    input  inst_req, inst_addr, inst_rready,
    input  data_req, data_we, data_addr, data_wdata, data_rready,
    input  ram_read_data,
    output inst_gnt, inst_rvalid, inst_rdata,
    output data_gnt, data_rvalid, data_rdata,
    output ram_en, ram_write_en, ram_addr, ram_write_data
  );

  modport master (
    output inst_req, inst_addr, inst_rready,
    output data_req, data_we, data_addr, data_wdata, data_rready,
    output ram_read_data,
    input  inst_gnt, inst_rvalid, inst_rdata,
    input  data_gnt, data_rvalid, data_rdata,
    input  ram_en, ram_write_en, ram_addr, ram_write_data
  );

endinterface

// File: rtl/ram_arbiter_rsp_slot.sv
// One-deep response register per requester; can_accept says a new grant will not
// overwrite a response the requester has not yet consumed.
module ram_arbiter_rsp_slot #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_grant,
  input  logic [DATA_WIDTH-1:0] i_capture_data,
  input  logic                  i_rready,
  output logic                  o_rvalid,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_can_accept
);

  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else if (i_grant) begin
      r_rvalid <= 1'b1;
      r_rdata  <= i_capture_data;
    end else if (i_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign o_rvalid     = r_rvalid;
  assign o_rdata      = r_rdata;
  assign o_can_accept = !r_rvalid || i_rready;

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing a single-port RAM between instruction fetch and load/store.
//   state (r_last_grant) | meaning
//   PORT_INST            | fetch was served last; data wins the next tie
//   PORT_DATA            | load/store was served last; fetch wins the next tie
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_BUS,
  parameter int DATA_WIDTH = DATA_BUS,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ram_arbiter_if.slave         bus,
  output logic [CNT_WIDTH-1:0] conflict_cnt
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  port_id_e              r_last_grant;
  port_id_e              w_last_grant_nxt;
  logic                  w_can_i;
  logic                  w_can_d;
  logic                  w_elig_i;
  logic                  w_elig_d;
  logic                  w_gnt_i;
  logic                  w_gnt_d;
  logic                  w_ram_en;
  logic [BE_WIDTH-1:0]   w_ram_we;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [DATA_WIDTH-1:0] w_ram_wdata;
  logic [DATA_WIDTH-1:0] w_data_capture;
  logic [DATA_WIDTH-1:0] w_inst_rdata;
  logic [DATA_WIDTH-1:0] w_data_rdata;
  logic                  w_inst_rvalid;
  logic                  w_data_rvalid;
  logic [CNT_WIDTH-1:0]  r_conflict_cnt;

  assign w_elig_i = bus.inst_req && w_can_i;
  assign w_elig_d = bus.data_req && w_can_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_last_grant <= PORT_INST;
    else        r_last_grant <= w_last_grant_nxt;
  end

  always_comb begin
    w_last_grant_nxt = r_last_grant;
    if (w_gnt_i)      w_last_grant_nxt = PORT_INST;
    else if (w_gnt_d) w_last_grant_nxt = PORT_DATA;
  end

  // Grants are gated by rst_n so nothing reaches the RAM during reset.
  always_comb begin
    w_gnt_i     = 1'b0;
    w_gnt_d     = 1'b0;
    w_ram_en    = 1'b0;
    w_ram_we    = '0;
    w_ram_addr  = '0;
    w_ram_wdata = '0;
    if (rst_n) begin
      if (w_elig_i && w_elig_d) begin
        w_gnt_d = (r_last_grant == PORT_INST);
        w_gnt_i = (r_last_grant == PORT_DATA);
      end else begin
        w_gnt_i = w_elig_i;
        w_gnt_d = w_elig_d;
      end
    end
    if (w_gnt_i) begin
      w_ram_en   = 1'b1;
      w_ram_addr = bus.inst_addr;
    end else if (w_gnt_d) begin
      w_ram_en    = 1'b1;
      w_ram_we    = bus.data_we;
      w_ram_addr  = bus.data_addr;
      w_ram_wdata = bus.data_wdata;
    end
  end

  // A store is acknowledged with zero data rather than the pre-write RAM word.
  assign w_data_capture = (bus.data_we == '0) ? bus.ram_read_data : '0;

  ram_arbiter_rsp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_inst_slot (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_grant        (w_gnt_i),
    .i_capture_data (bus.ram_read_data),
    .i_rready       (bus.inst_rready),
    .o_rvalid       (w_inst_rvalid),
    .o_rdata        (w_inst_rdata),
    .o_can_accept   (w_can_i)
  );

  ram_arbiter_rsp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_data_slot (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_grant        (w_gnt_d),
    .i_capture_data (w_data_capture),
    .i_rready       (bus.data_rready),
    .o_rvalid       (w_data_rvalid),
    .o_rdata        (w_data_rdata),
    .o_can_accept   (w_can_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= '0;
    end else if (w_elig_i && w_elig_d && (r_conflict_cnt != {CNT_WIDTH{1'b1}})) begin
      r_conflict_cnt <= r_conflict_cnt + CNT_WIDTH'(1);
    end
  end

  assign bus.inst_gnt       = w_gnt_i;
  assign bus.data_gnt       = w_gnt_d;
  assign bus.inst_rvalid    = w_inst_rvalid;
  assign bus.inst_rdata     = w_inst_rdata;
  assign bus.data_rvalid    = w_data_rvalid;
  assign bus.data_rdata     = w_data_rdata;
  assign bus.ram_en         = w_ram_en;
  assign bus.ram_write_en   = w_ram_we;
  assign bus.ram_addr       = w_ram_addr;
  assign bus.ram_write_data = w_ram_wdata;
  assign conflict_cnt       = r_conflict_cnt;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic against a
// transaction-level model with its own copy of the RAM contents.
module tb_ram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        mem_clr;
  logic [15:0] cnt;
  logic [3:0]  cnt4;
  logic [31:0] mem [64];
  int          n_vec;
  int          n_err;

  ram_arbiter_if bus ();
  ram_arbiter_if bus4 ();

  ram_arbiter u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .conflict_cnt (cnt)
  );

  ram_arbiter #(.CNT_WIDTH(4)) u_dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus4),
    .conflict_cnt (cnt4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAM: combinational read, byte-masked write at the clock edge.
  assign bus.ram_read_data  = mem[bus.ram_addr[7:2]];
  assign bus4.ram_read_data = '0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (bus.ram_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_write_en[b]) mem[bus.ram_addr[7:2]][8*b +: 8] <= bus.ram_write_data[8*b +: 8];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [64];
  bit          m_last_data;
  bit          m_iv, m_dv;
  logic [31:0] m_ird, m_drd;
  logic [15:0] m_cnt;
  bit          e_gi, e_gd, e_en, e_conf;
  logic [3:0]  e_we;
  logic [31:0] e_addr, e_wd;

  function automatic void model_reset();
    m_last_data = 1'b0;
    m_iv = 1'b0;  m_dv = 1'b0;
    m_ird = '0;   m_drd = '0;
    m_cnt = '0;
  endfunction

  function automatic void predict();
    bit ei, ed;
    ei = bus.inst_req && (!m_iv || bus.inst_rready);
    ed = bus.data_req && (!m_dv || bus.data_rready);
    e_conf = ei && ed;
    e_gi = 1'b0; e_gd = 1'b0;
    if (rst_n) begin
      if (ei && ed) begin
        e_gd = !m_last_data;
        e_gi = m_last_data;
      end else begin
        e_gi = ei;
        e_gd = ed;
      end
    end
    e_en = e_gi || e_gd;
    e_we = e_gd ? bus.data_we : 4'h0;
    e_addr = e_gi ? bus.inst_addr : (e_gd ? bus.data_addr : 32'h0);
    e_wd = e_gd ? bus.data_wdata : 32'h0;
  endfunction

  function automatic void commit();
    logic [31:0] cap;
    if (!rst_n) begin
      model_reset();
      return;
    end
    cap = ref_mem[e_addr[7:2]];
    if (e_gi) begin m_iv = 1'b1; m_ird = cap; end
    else if (bus.inst_rready) m_iv = 1'b0;
    if (e_gd) begin m_dv = 1'b1; m_drd = (e_we == 4'h0) ? cap : 32'h0; end
    else if (bus.data_rready) m_dv = 1'b0;
    for (int b = 0; b < 4; b++)
      if (e_en && e_we[b]) ref_mem[e_addr[7:2]][8*b +: 8] = e_wd[8*b +: 8];
    if (e_gi) m_last_data = 1'b0;
    else if (e_gd) m_last_data = 1'b1;
    if (e_conf && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
  endfunction

  task automatic settle();
    #1;
    predict();
  endtask

  task automatic tick();
    @(posedge clk);
    commit();
    #1;
  endtask

  task automatic idle();
    bus.inst_req = 1'b0; bus.inst_addr = '0; bus.inst_rready = 1'b1;
    bus.data_req = 1'b0; bus.data_we = '0; bus.data_addr = '0;
    bus.data_wdata = '0; bus.data_rready = 1'b1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    idle();
    settle();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_clr = 1'b1;
    idle();
    bus.inst_req = 1'b1; bus.data_req = 1'b1;
    bus4.inst_req = 1'b0; bus4.inst_addr = '0; bus4.inst_rready = 1'b1;
    bus4.data_req = 1'b0; bus4.data_we = '0; bus4.data_addr = '0;
    bus4.data_wdata = '0; bus4.data_rready = 1'b1;
    model_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    settle();
    tick();
    tick();
    mem_clr = 1'b0;
    n_vec++;
    if ({bus.inst_gnt, bus.data_gnt, bus.ram_en, bus.ram_write_en} !== 7'h0) begin
      n_err++;
      $display("FAIL reset_gating: gnt_i/gnt_d/en/we=%b required 0", {bus.inst_gnt, bus.data_gnt, bus.ram_en, bus.ram_write_en});
    end
    n_vec++;
    if ({bus.inst_rvalid, bus.data_rvalid, bus.inst_rdata, bus.data_rdata, cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_regs: iv=%b dv=%b ird=%h drd=%h cnt=%0d required all 0",
               bus.inst_rvalid, bus.data_rvalid, bus.inst_rdata, bus.data_rdata, cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    settle();
    tick();
  endtask

  task automatic test_conflict_rr();
    bit exp_d;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.inst_req = 1'b1; bus.inst_addr = 32'h4;
      bus.data_req = 1'b1; bus.data_addr = 32'h8;
      settle();
      exp_d = (k % 2 == 0);
      n_vec++;
      if ({bus.inst_gnt, bus.data_gnt} !== {!exp_d, exp_d}) begin
        n_err++;
        $display("FAIL rr_grant[%0d]: gnt_i/gnt_d=%b%b required %b%b", k, bus.inst_gnt, bus.data_gnt, !exp_d, exp_d);
      end
      tick();
      n_vec++;
      if ({bus.inst_rvalid, bus.data_rvalid} !== {!exp_d, exp_d}) begin
        n_err++;
        $display("FAIL rr_rvalid[%0d]: iv/dv=%b%b required %b%b", k, bus.inst_rvalid, bus.data_rvalid, !exp_d, exp_d);
      end
    end
    n_vec++;
    if (cnt !== 16'd6 || cnt !== m_cnt) begin
      n_err++;
      $display("FAIL rr_conflict_cnt: got %0d required 6 (model %0d)", cnt, m_cnt);
    end
    idle_cycle();
  endtask

  task automatic test_fetch();
    @(negedge clk);
    idle();
    bus.data_req = 1'b1; bus.data_we = 4'hF; bus.data_addr = 32'h10; bus.data_wdata = 32'hDEADBEEF;
    settle();
    n_vec++;
    if ({bus.data_gnt, bus.ram_write_en} !== 5'b1_1111) begin
      n_err++;
      $display("FAIL fetch_preload_gnt: gnt_d=%b we=%b required 1 1111", bus.data_gnt, bus.ram_write_en);
    end
    tick();
    n_vec++;
    if ({bus.data_rvalid, bus.data_rdata} !== {1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL fetch_store_ack: dv=%b drd=%h required 1 00000000", bus.data_rvalid, bus.data_rdata);
    end
    @(negedge clk);
    idle();
    bus.inst_req = 1'b1; bus.inst_addr = 32'h10;
    settle();
    n_vec++;
    if ({bus.inst_gnt, bus.ram_en, bus.ram_write_en, bus.ram_addr} !== {1'b1, 1'b1, 4'h0, 32'h10}) begin
      n_err++;
      $display("FAIL fetch_gnt: gnt_i=%b en=%b we=%b addr=%h required 1 1 0000 00000010",
               bus.inst_gnt, bus.ram_en, bus.ram_write_en, bus.ram_addr);
    end
    tick();
    n_vec++;
    if ({bus.inst_rvalid, bus.inst_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL fetch_rsp: iv=%b ird=%h required 1 deadbeef", bus.inst_rvalid, bus.inst_rdata);
    end
    idle_cycle();
  endtask

  task automatic test_partial_write();
    logic [3:0]  t_we [3];
    logic [31:0] t_wd [3];
    logic [31:0] t_rd [3];
    t_we = '{4'hF, 4'h3, 4'h0};
    t_wd = '{32'hAABBCCDD, 32'h12345678, 32'h0};
    t_rd = '{32'h0, 32'h0, 32'hAABB5678};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle();
      bus.data_req = 1'b1; bus.data_addr = 32'h20; bus.data_we = t_we[k]; bus.data_wdata = t_wd[k];
      settle();
      tick();
      n_vec++;
      if ({bus.data_rvalid, bus.data_rdata} !== {1'b1, t_rd[k]}) begin
        n_err++;
        $display("FAIL partial_write[%0d]: dv=%b drd=%h required 1 %h", k, bus.data_rvalid, bus.data_rdata, t_rd[k]);
      end
    end
    idle_cycle();
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    idle();
    bus.inst_req = 1'b1; bus.inst_addr = 32'h10; bus.inst_rready = 1'b0;
    settle();
    tick();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.data_req = (k % 2 == 0);
      bus.data_addr = 32'($urandom_range(0, 63)) << 2;
      settle();
      n_vec++;
      if ({bus.inst_gnt, bus.data_gnt} !== {1'b0, bus.data_req}) begin
        n_err++;
        $display("FAIL bp_gnt[%0d]: gnt_i/gnt_d=%b%b required 0%b", k, bus.inst_gnt, bus.data_gnt, bus.data_req);
      end
      tick();
      n_vec++;
      if ({bus.inst_rvalid, bus.inst_rdata, bus.data_rvalid, bus.data_rdata} !== {1'b1, 32'hDEADBEEF, m_dv, m_drd}) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: iv=%b ird=%h dv=%b drd=%h required 1 deadbeef %b %h",
                 k, bus.inst_rvalid, bus.inst_rdata, bus.data_rvalid, bus.data_rdata, m_dv, m_drd);
      end
    end
    @(negedge clk);
    bus.data_req = 1'b0;
    bus.inst_rready = 1'b1;
    settle();
    n_vec++;
    if (bus.inst_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: gnt_i=%b required 1", bus.inst_gnt);
    end
    tick();
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    idle();
    bus.data_req = 1'b1; bus.data_addr = 32'h10; bus.data_rready = 1'b0;
    settle();
    tick();
    @(negedge clk);
    bus.inst_req = 1'b1; bus.inst_addr = 32'h20;
    settle();
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.inst_rvalid, bus.data_rvalid, bus.inst_gnt, bus.data_gnt, bus.ram_en, bus.ram_write_en, cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_mid: iv=%b dv=%b gi=%b gd=%b en=%b we=%b cnt=%0d required all 0",
               bus.inst_rvalid, bus.data_rvalid, bus.inst_gnt, bus.data_gnt, bus.ram_en, bus.ram_write_en, cnt);
    end
    model_reset();
    predict();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    bus.data_rready = 1'b1;
    settle();
    n_vec++;
    if ({bus.inst_gnt, bus.data_gnt} !== 2'b01) begin
      n_err++;
      $display("FAIL reset_first_conflict: gnt_i/gnt_d=%b%b required 01", bus.inst_gnt, bus.data_gnt);
    end
    tick();
    n_vec++;
    if ({bus.data_rvalid, bus.data_rdata} !== {1'b1, m_drd}) begin
      n_err++;
      $display("FAIL reset_first_rsp: dv=%b drd=%h required 1 %h", bus.data_rvalid, bus.data_rdata, m_drd);
    end
    idle_cycle();
  endtask

  task automatic test_saturate();
    logic [3:0] exp;
    bus4.inst_req = 1'b1;
    bus4.data_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      settle();
      tick();
      exp = (k > 15) ? 4'd15 : 4'(k);
      n_vec++;
      if (cnt4 !== exp) begin
        n_err++;
        $display("FAIL saturate[%0d]: cnt=%0d required %0d", k, cnt4, exp);
      end
    end
    bus4.inst_req = 1'b0;
    bus4.data_req = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      bus.inst_req    = ($urandom_range(0, 3) != 0);
      bus.inst_addr   = 32'($urandom_range(0, 255));
      bus.inst_rready = ($urandom_range(0, 3) != 0);
      bus.data_req    = ($urandom_range(0, 3) != 0);
      bus.data_we     = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      bus.data_addr   = 32'($urandom_range(0, 255));
      bus.data_wdata  = $urandom;
      bus.data_rready = ($urandom_range(0, 3) != 0);
      settle();
      n_vec++;
      if ({bus.inst_gnt, bus.data_gnt, bus.ram_en, bus.ram_write_en, bus.ram_addr, bus.ram_write_data} !==
          {e_gi, e_gd, e_en, e_we, e_addr, e_wd}) begin
        n_err++;
        $display("FAIL rand_comb[%0d]: gi=%b gd=%b en=%b we=%h addr=%h wd=%h required %b %b %b %h %h %h",
                 k, bus.inst_gnt, bus.data_gnt, bus.ram_en, bus.ram_write_en, bus.ram_addr, bus.ram_write_data,
                 e_gi, e_gd, e_en, e_we, e_addr, e_wd);
      end
      tick();
      n_vec++;
      if ({bus.inst_rvalid, bus.inst_rdata, bus.data_rvalid, bus.data_rdata, cnt} !==
          {m_iv, m_ird, m_dv, m_drd, m_cnt}) begin
        n_err++;
        $display("FAIL rand_rsp[%0d]: iv=%b ird=%h dv=%b drd=%h cnt=%0d required %b %h %b %h %0d",
                 k, bus.inst_rvalid, bus.inst_rdata, bus.data_rvalid, bus.data_rdata, cnt,
                 m_iv, m_ird, m_dv, m_drd, m_cnt);
      end
    end
    idle_cycle();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_conflict_rr();
    test_fetch();
    test_partial_write();
    test_backpressure();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
